// File: rtl/instr_stream_encoder_pkg.sv
// Shared RV32I opcode constants, request kinds, immediate limits and FSM states
// for the instruction-stream encoder.
package instr_stream_encoder_pkg;

  typedef enum logic [2:0] {
    KIND_LW     = 3'd0,
    KIND_SW     = 3'd1,
    KIND_RTYPE  = 3'd2,
    KIND_BRANCH = 3'd3,
    KIND_ITYPE  = 3'd4,
    KIND_JALR   = 3'd5,
    KIND_JAL    = 3'd6,
    KIND_LUI    = 3'd7
  } req_kind_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } state_e;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  localparam int IMM_I_MIN = -2048;
  localparam int IMM_I_MAX = 2047;
  localparam int IMM_B_MIN = -4096;
  localparam int IMM_B_MAX = 4094;
  localparam int IMM_J_MIN = -1048576;
  localparam int IMM_J_MAX = 1048574;

  function automatic logic imm_in_range(input logic signed [31:0] v, input int lo, input int hi);
    return (v >= lo) && (v <= hi);
  endfunction

  // The core only decodes beq, bne, blt and bge.
  function automatic logic branch_f3_ok(input logic [2:0] f3);
    return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b100) || (f3 == 3'b101);
  endfunction

endpackage

// File: rtl/instr_stream_encoder_if.sv
// Request channel of the instruction-stream encoder: one abstract instruction
// per valid/ready handshake.
interface instr_stream_encoder_if;
  import instr_stream_encoder_pkg::*;

  logic        req_valid;
  logic        req_ready;
  req_kind_e   req_kind;
  logic [4:0]  req_rd;
  logic [4:0]  req_rs1;
  logic [4:0]  req_rs2;
  logic [2:0]  req_funct3;
  logic        req_funct7b5;
  logic [31:0] req_imm;
  logic        req_last;

  modport master (
    output req_valid, req_kind, req_rd, req_rs1, req_rs2,
    output req_funct3, req_funct7b5, req_imm, req_last,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_kind, req_rd, req_rs1, req_rs2,
    input  req_funct3, req_funct7b5, req_imm, req_last,
    output req_ready
  );

endinterface

// File: rtl/instr_stream_encoder_fmt_enc.sv
// Combinational RV32I formatter: turns one abstract request into its 32-bit
// instruction word and flags requests whose fields cannot be encoded.
module instr_fmt_enc
  import instr_stream_encoder_pkg::*;
(
  input  req_kind_e   kind,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        legal
);

  // Per-kind field packing and legality check
  always_comb begin
    word  = 32'd0;
    legal = 1'b0;
    case (kind)
      KIND_LW: begin
        word  = {imm[11:0], rs1, 3'b010, rd, OP_LW};
        legal = imm_in_range(imm, IMM_I_MIN, IMM_I_MAX);
      end
      KIND_SW: begin
        word  = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OP_SW};
        legal = imm_in_range(imm, IMM_I_MIN, IMM_I_MAX);
      end
      KIND_RTYPE: begin
        word  = {1'b0, funct7b5, 5'b00000, rs2, rs1, funct3, rd, OP_R};
        legal = 1'b1;
      end
      KIND_BRANCH: begin
        word  = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_BR};
        legal = imm_in_range(imm, IMM_B_MIN, IMM_B_MAX) && (imm[0] == 1'b0) && branch_f3_ok(funct3);
      end
      KIND_ITYPE: begin
        // Right shifts carry the arithmetic/logical selector in imm[10].
        if (funct3 == 3'b101) begin
          word = {1'b0, funct7b5, 5'b00000, imm[4:0], rs1, funct3, rd, OP_I};
        end else begin
          word = {imm[11:0], rs1, funct3, rd, OP_I};
        end
        legal = imm_in_range(imm, IMM_I_MIN, IMM_I_MAX);
      end
      KIND_JALR: begin
        word  = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
        legal = imm_in_range(imm, IMM_I_MIN, IMM_I_MAX);
      end
      KIND_JAL: begin
        word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
        legal = imm_in_range(imm, IMM_J_MIN, IMM_J_MAX) && (imm[0] == 1'b0);
      end
      KIND_LUI: begin
        word  = {imm[31:12], rd, OP_LUI};
        legal = (imm[11:0] == 12'd0);
      end
      default: begin
        word  = 32'd0;
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_stream_encoder.sv
// Loads an encoded RV32I program into IMEM: one request in, one registered
// word-aligned write out, with session DONE/ERROR bookkeeping.
module instr_stream_encoder
  import instr_stream_encoder_pkg::*;
#(
  parameter int MAX_WORDS = 256,
  parameter int COUNT_W   = 9
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [31:0]            base_addr,
  instr_stream_encoder_if.slave  req,
  output logic                   imem_we,
  output logic [31:0]            imem_addr,
  output logic [31:0]            imem_wdata,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [COUNT_W-1:0]     count
);

  localparam logic [COUNT_W-1:0] COUNT_MAX = COUNT_W'(MAX_WORDS);

  state_e             state_r, state_s;
  logic [31:0]        next_addr_r, next_addr_s;
  logic [COUNT_W-1:0] count_r, count_s;
  logic               we_r, we_s;
  logic [31:0]        addr_r, addr_s;
  logic [31:0]        wdata_r, wdata_s;
  logic               busy_r, busy_s;
  logic               done_r, done_s;
  logic               err_r, err_s;
  logic               ready_r, ready_s;
  logic [31:0]        word_s;
  logic               legal_s;

  instr_fmt_enc u_fmt_enc (
    .kind     (req.req_kind),
    .rd       (req.req_rd),
    .rs1      (req.req_rs1),
    .rs2      (req.req_rs2),
    .funct3   (req.req_funct3),
    .funct7b5 (req.req_funct7b5),
    .imm      (req.req_imm),
    .word     (word_s),
    .legal    (legal_s)
  );

  // Next-state and next-output computation for the load session
  always_comb begin
    state_s     = state_r;
    next_addr_s = next_addr_r;
    count_s     = count_r;
    we_s        = 1'b0;
    addr_s      = addr_r;
    wdata_s     = wdata_r;
    done_s      = done_r;
    err_s       = err_r;
    case (state_r)
      ST_LOAD: begin
        if (req.req_valid && ready_r) begin
          if (legal_s) begin
            we_s        = 1'b1;
            addr_s      = next_addr_r;
            wdata_s     = word_s;
            next_addr_s = next_addr_r + 32'd4;
            count_s     = count_r + COUNT_W'(1);
            // A last request that also fills the session still ends cleanly.
            if (req.req_last) begin
              state_s = ST_DONE;
              done_s  = 1'b1;
            end else if ((count_r + COUNT_W'(1)) == COUNT_MAX) begin
              state_s = ST_ERROR;
              err_s   = 1'b1;
            end else begin
              state_s = ST_LOAD;
            end
          end else begin
            state_s = ST_ERROR;
            err_s   = 1'b1;
          end
        end else begin
          state_s = ST_LOAD;
        end
      end
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_s     = ST_LOAD;
          done_s      = 1'b0;
          err_s       = 1'b0;
          count_s     = '0;
          next_addr_s = base_addr & 32'hFFFF_FFFC;
        end else begin
          state_s = state_r;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    busy_s  = (state_s == ST_LOAD);
    ready_s = (state_s == ST_LOAD) && (count_s != COUNT_MAX);
  end

  // State, address/counter and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      next_addr_r <= 32'd0;
      count_r     <= '0;
      we_r        <= 1'b0;
      addr_r      <= 32'd0;
      wdata_r     <= 32'd0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      ready_r     <= 1'b0;
    end else begin
      state_r     <= state_s;
      next_addr_r <= next_addr_s;
      count_r     <= count_s;
      we_r        <= we_s;
      addr_r      <= addr_s;
      wdata_r     <= wdata_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      err_r       <= err_s;
      ready_r     <= ready_s;
    end
  end

  assign req.req_ready = ready_r;
  assign imem_we       = we_r;
  assign imem_addr     = addr_r;
  assign imem_wdata    = wdata_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign err           = err_r;
  assign count         = count_r;

endmodule
